pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding, the packed
// pipeline-register control bundle and the canned control patterns.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_bubble;
  } ctrl_t;

  // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble
  localparam ctrl_t CTRL_NORMAL = ctrl_t'(7'b1101010);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(7'b1111110);
  localparam ctrl_t CTRL_LDUSE  = ctrl_t'(7'b0001110);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000001);
  localparam ctrl_t CTRL_SAFE   = ctrl_t'(7'b0010101);

  // Controls for a cycle in which the pipe is allowed to move.
  // A taken branch squashes the younger instructions, which makes any
  // load-use hazard on them moot.
  function automatic ctrl_t advance_ctrl(input logic branch, input logic load_use);
    ctrl_t c;
    c = CTRL_NORMAL;
    if (branch) begin
      c = CTRL_BRANCH;
    end else if (load_use) begin
      c = CTRL_LDUSE;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// source operands of the instruction in IF/ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_idex_memread,
  input  logic [REG_ADDR_W-1:0] i_idex_rd,
  input  logic                  i_idex_rd_valid,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs,
  input  logic                  i_ifid_rs_valid,
  input  logic [REG_ADDR_W-1:0] i_ifid_rt,
  input  logic                  i_ifid_rt_valid,
  output logic                  o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = i_ifid_rs_valid & (i_ifid_rs == i_idex_rd);
  assign w_rt_hit   = i_ifid_rt_valid & (i_ifid_rt == i_idex_rd);
  assign o_load_use = i_idex_memread & i_idex_rd_valid & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: RUN/MEMWAIT/HALT/ERR FSM with a data-memory
// timeout. Define PIPE_CTRL_PERF_EN to build the saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_rd_valid,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_rs_valid,
  input  logic                  ifid_rt_valid,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_done,
  input  logic                  halt_in,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_bubble,
  output logic                  exmem_en,
  output logic                  memwb_bubble,
  output logic                  halted,
  output logic                  mem_err,
  output logic [1:0]            state,
  output logic [15:0]           stall_cycles
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(MEM_TIMEOUT);
  localparam logic             TO_ENABLED = (MEM_TIMEOUT != 0);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_to_cnt_next;
  ctrl_t            w_ctrl;
  logic             w_load_use;
  logic             w_mem_stall;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .i_idex_memread  (idex_memread),
    .i_idex_rd       (idex_rd),
    .i_idex_rd_valid (idex_rd_valid),
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rs_valid (ifid_rs_valid),
    .i_ifid_rt       (ifid_rt),
    .i_ifid_rt_valid (ifid_rt_valid),
    .o_load_use      (w_load_use)
  );

  assign w_mem_stall = dmem_req & ~dmem_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_to_cnt <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_to_cnt_next = r_to_cnt;
    w_ctrl        = CTRL_SAFE;
    case (r_state)
      ST_RUN: begin
        w_to_cnt_next = '0;
        if (halt_in) begin
          w_ctrl       = CTRL_SAFE;
          w_next_state = ST_HALT;
        end else if (w_mem_stall) begin
          w_ctrl        = CTRL_FREEZE;
          w_next_state  = ST_MEMWAIT;
          w_to_cnt_next = CNT_W'(1);
        end else begin
          w_ctrl = advance_ctrl(ex_branch_taken, w_load_use);
        end
      end
      ST_MEMWAIT: begin
        // halt_in is not looked at here: WB is being bubbled, so it cannot be real.
        if (dmem_done) begin
          w_ctrl        = advance_ctrl(ex_branch_taken, w_load_use);
          w_next_state  = ST_RUN;
          w_to_cnt_next = '0;
        end else begin
          w_ctrl = CTRL_FREEZE;
          if (TO_ENABLED && (r_to_cnt == TO_LIMIT)) begin
            w_next_state = ST_ERR;
          end else if (r_to_cnt != {CNT_W{1'b1}}) begin
            w_to_cnt_next = r_to_cnt + CNT_W'(1);
          end
        end
      end
      ST_HALT: w_ctrl = CTRL_SAFE;
      ST_ERR:  w_ctrl = CTRL_SAFE;
      default: w_next_state = ST_RUN;
    endcase
    // Reset must drain the pipe immediately, not one clock later.
    if (!rst) begin
      w_ctrl = CTRL_SAFE;
    end
  end

  assign pc_en        = w_ctrl.pc_en;
  assign ifid_en      = w_ctrl.ifid_en;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_en      = w_ctrl.idex_en;
  assign idex_bubble  = w_ctrl.idex_bubble;
  assign exmem_en     = w_ctrl.exmem_en;
  assign memwb_bubble = w_ctrl.memwb_bubble;
  assign halted       = rst & (r_state == ST_HALT);
  assign mem_err      = rst & (r_state == ST_ERR);
  assign state        = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall_cycles;
  logic        w_stall_evt;

  assign w_stall_evt = ((r_state == ST_RUN) || (r_state == ST_MEMWAIT)) && !w_ctrl.pc_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall_evt && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
